mul_issue_sequencer: RTL and testbench
======================================

// Module: mul_issue_sequencer
// PURPOSE
//  Sequences the iterative Booth radix-4 multiply unit between issue and writeback stages.
//  - Accepts one RV32M multiply op at a time over a valid/ready handshake.
//  - Latches the operands and drives the core's clock enable for exactly one full pass.
//  - Applies unsigned/signed-unsigned high-word correction to the core's signed product.
//  - Holds the tagged result until writeback accepts it.
//  - Handles flush mid-operation and skips the core when either operand is zero.
// PARAMETERS
//  XLEN        32   operand/result width
//  TAG_W       5    destination-register tag width
//  MUL_CYCLES  17   core clk_en cycles per op (1 load + 16 Booth iterations)
// PORTS
//  clk_i           in   1       clock
//  rst_n_i         in   1       reset, asynchronous, active-low
//  issue_valid_i   in   1       op request valid
//  issue_ready_o   out  1       sequencer can accept op this cycle
//  issue_op_i      in   2       00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//  issue_rs1_i     in   XLEN    operand a (always signed for MULH/MULHSU)
//  issue_rs2_i     in   XLEN    operand b
//  issue_tag_i     in   TAG_W   destination tag, echoed on wb_tag_o
//  flush_i         in   1       kill the op in flight; result is discarded
//  core_a_o        out  XLEN    to core multiplier_i; held stable for the whole op
//  core_b_o        out  XLEN    to core multiplicand_i; held stable for the whole op
//  core_op_o       out  mul_ops_e  MUL_ for op 00, MULH_ for all high-word ops
//  core_clk_en_o   out  1       core clock enable
//  core_result_i   in   XLEN    core result_o
//  core_state_i    in   fu_state_e  core fu_state_o
//  wb_valid_o      out  1       result valid
//  wb_ready_i      in   1       writeback accepts result
//  wb_data_o       out  XLEN    corrected result
//  wb_tag_o        out  TAG_W   tag of the result
//  seq_err_o       out  1       sticky: core not FREE when its result was sampled
// BEHAVIOUR
//  Reset values: state=IDLE; issue_ready_o=1; core_clk_en_o=0; wb_valid_o=0; seq_err_o=0.
//   wb_data_o=0, wb_tag_o=0, core_a_o=0, core_b_o=0.
//   The core's rst_n_i shares this reset; reset must be held for >=1 clk_i edge.
//  Handshake: an op is accepted on an edge where issue_valid_i & issue_ready_o.
//   On acceptance, op, rs1, rs2 and tag are latched.
//  issue_ready_o = (state==IDLE) | (state==DONE & wb_ready_i). No combinational path from issue_valid_i.
//  States:
//   IDLE: waits for an accepted op.
//    If either operand is 0, go to DONE with wb_data=0 (fast path; core untouched).
//    Otherwise go to RUN with cnt=0.
//   RUN: core_clk_en_o=1. cnt increments each cycle.
//    On the edge where cnt==MUL_CYCLES-1, go to CORR.
//   CORR: core_clk_en_o=0. Sample core_result_i as hi_s/lo. Write corrected value to wb_data_o.
//    Set seq_err_o if core_state_i!=FREE. Go to DONE.
//   DONE: wb_valid_o=1; data and tag are held stable while wb_ready_i=0.
//    On wb_ready_i, go to IDLE, or straight into the next RUN/DONE if a new op is accepted on the same edge.
//   DRAIN: entered from RUN on flush_i. core_clk_en_o stays 1 until cnt reaches MUL_CYCLES-1, then IDLE.
//    issue_ready_o=0. No wb_valid_o.
//    The core's internal counter must return to 0, so the RUN count is never truncated.
//  Flush in IDLE, CORR or DONE: drop any pending result and go to IDLE next edge. flush_i beats wb_ready_i.
//  Correction, all arithmetic mod 2^XLEN (core computes signed a*b):
//   MUL     lo
//   MULH    hi_s
//   MULHSU  hi_s + (b[XLEN-1] ? a : 0)
//   MULHU   hi_s + (a[XLEN-1] ? b : 0) + (b[XLEN-1] ? a : 0)
//  Latency: wb_valid_o rises MUL_CYCLES+1 edges after the accepting edge; fast path: 1 edge.
//  Throughput: 1 op per MUL_CYCLES+1 cycles, assuming no back-pressure.
// TESTING
//  T1 MUL a=7, b=0xFFFFFFFD, tag=5 -> wb_data=0xFFFFFFEB, wb_tag=5, wb_valid 18 cycles after accept.
//     core_clk_en high exactly 17 cycles.
//  T2 High words:
//     MULH a=b=0x80000000 -> 0x40000000.
//     MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
//     MULHSU a=b=0xFFFFFFFF -> 0xFFFFFFFF.
//  T3 Zero fast path: MUL a=0x1234, b=0 -> wb_valid=1 one cycle after accept with data 0.
//     core_clk_en never asserts.
//  T4 flush_i on RUN cycle 5 -> no wb_valid; core_clk_en stays high 12 more cycles; issue_ready low until IDLE.
//     Next MUL 3*4 -> 12, seq_err_o=0.
//  T5 Back-pressure: wb_ready=0 for 10 cycles -> data/tag stable, issue_ready=0.
//     Then wb_ready=1 with new op valid -> result retired and new op accepted on the same edge.
//  T6 rst_n_i asserted mid-RUN (async) -> outputs at reset values immediately.
//     After release, MULHU 2*3 -> 0 with seq_err_o=0.

Source files
------------

// File: rtl/mul_issue_sequencer.sv
// Issue-to-writeback sequencer for an iterative Booth radix-4 multiply core.
// Latches one RV32M multiply op, runs the core for a full pass, then corrects and holds the tagged result.
package mul_issue_sequencer_pkg;
    typedef enum logic {MUL_ = 1'b0, MULH_ = 1'b1} mul_ops_e;
    typedef enum logic {FREE = 1'b0, BUSY = 1'b1} fu_state_e;
endpackage

module mul_issue_sequencer
    import mul_issue_sequencer_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 5,
    parameter int MUL_CYCLES = 17
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic [1:0]       issue_op_i,
    input  logic [XLEN-1:0]  issue_rs1_i,
    input  logic [XLEN-1:0]  issue_rs2_i,
    input  logic [TAG_W-1:0] issue_tag_i,
    input  logic             flush_i,
    output logic [XLEN-1:0]  core_a_o,
    output logic [XLEN-1:0]  core_b_o,
    output mul_ops_e         core_op_o,
    output logic             core_clk_en_o,
    input  logic [XLEN-1:0]  core_result_i,
    input  fu_state_e        core_state_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [XLEN-1:0]  wb_data_o,
    output logic [TAG_W-1:0] wb_tag_o,
    output logic             seq_err_o
);
    localparam int CNT_W = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  XZERO    = {XLEN{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_CORR  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    logic             err_q, err_d;
    logic             accept_s;
    logic             zero_s;

    // The core always multiplies signed*signed; unsigned views of a negative
    // operand add the other operand into the high word.
    function automatic logic [XLEN-1:0] correct_result(input logic [1:0] op,
                                                       input logic [XLEN-1:0] a,
                                                       input logic [XLEN-1:0] b,
                                                       input logic [XLEN-1:0] r);
        logic [XLEN-1:0] add_a;
        logic [XLEN-1:0] add_b;
        add_a = b[XLEN-1] ? a : XZERO;
        add_b = a[XLEN-1] ? b : XZERO;
        case (op)
            2'b00:   return r;
            2'b01:   return r;
            2'b10:   return r + add_a;
            2'b11:   return r + add_a + add_b;
            default: return r;
        endcase
    endfunction

    assign issue_ready_o = (state_q == S_IDLE) | ((state_q == S_DONE) & wb_ready_i);
    assign accept_s      = issue_valid_i & issue_ready_o;
    assign zero_s        = (issue_rs1_i == XZERO) | (issue_rs2_i == XZERO);
    assign core_clk_en_o = (state_q == S_RUN) | (state_q == S_DRAIN);
    assign wb_valid_o    = (state_q == S_DONE);
    assign core_a_o      = a_q;
    assign core_b_o      = b_q;
    assign core_op_o     = (op_q == 2'b00) ? MUL_ : MULH_;
    assign wb_data_o     = wb_data_q;
    assign wb_tag_o      = wb_tag_q;
    assign seq_err_o     = err_q;

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        tag_d     = tag_q;
        wb_data_d = wb_data_q;
        wb_tag_d  = wb_tag_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_RUN: begin
                // A flush never cuts the pass short: the core's own counter must wrap.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = flush_i ? S_IDLE : S_CORR;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = flush_i ? S_DRAIN : S_RUN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_CORR: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    wb_data_d = correct_result(op_q, a_q, b_q, core_result_i);
                    wb_tag_d  = tag_q;
                    if (core_state_i != FREE) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (flush_i || wb_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        // Acceptance is only possible from IDLE or a retiring DONE, so it overrides the case above.
        if (accept_s && !flush_i) begin
            op_d = issue_op_i;
            if (zero_s) begin
                wb_data_d = XZERO;
                wb_tag_d  = issue_tag_i;
                state_d   = S_DONE;
            end else begin
                a_d     = issue_rs1_i;
                b_d     = issue_rs2_i;
                tag_d   = issue_tag_i;
                cnt_d   = {CNT_W{1'b0}};
                state_d = S_RUN;
            end
        end else begin
            op_d = op_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            op_q      <= 2'b00;
            a_q       <= XZERO;
            b_q       <= XZERO;
            tag_q     <= {TAG_W{1'b0}};
            wb_data_q <= XZERO;
            wb_tag_q  <= {TAG_W{1'b0}};
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tag_q     <= tag_d;
            wb_data_q <= wb_data_d;
            wb_tag_q  <= wb_tag_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_mul_issue_sequencer.sv
// Self-checking bench for mul_issue_sequencer with a behavioural 17-cycle signed multiply core.
module tb_mul_issue_sequencer;
    import mul_issue_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_ready;
    logic [1:0]  issue_op;
    logic [31:0] issue_rs1, issue_rs2;
    logic [4:0]  issue_tag;
    logic        flush;
    logic [31:0] core_a, core_b;
    mul_ops_e    core_op;
    logic        core_clk_en;
    logic [31:0] core_result;
    fu_state_e   core_state, c_state;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_tag;
    logic        seq_err;
    logic        core_stall;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mul_issue_sequencer dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .issue_op_i(issue_op), .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
        .issue_tag_i(issue_tag), .flush_i(flush),
        .core_a_o(core_a), .core_b_o(core_b), .core_op_o(core_op),
        .core_clk_en_o(core_clk_en), .core_result_i(core_result), .core_state_i(core_state),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_data_o(wb_data),
        .wb_tag_o(wb_tag), .seq_err_o(seq_err)
    );

    // Core stand-in: a full pass is 17 enabled edges, after which the signed product is presented.
    logic [4:0]  c_cnt;
    logic [63:0] c_prod;
    assign c_prod     = {{32{core_a[31]}}, core_a} * {{32{core_b[31]}}, core_b};
    assign core_state = core_stall ? BUSY : c_state;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_cnt <= 5'd0; c_state <= FREE; core_result <= 32'd0;
        end else if (core_clk_en) begin
            if (c_cnt == 5'd16) begin
                c_cnt <= 5'd0; c_state <= FREE;
                core_result <= (core_op == MUL_) ? c_prod[31:0] : c_prod[63:32];
            end else begin
                c_cnt <= c_cnt + 5'd1; c_state <= BUSY;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: architectural RV32M result from operands extended per signedness.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == 2'b11) ? {32'd0, a} : {{32{a[31]}}, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        int s;
        s = $urandom_range(0, 7);
        case (s)
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Present an op at a negedge; returns at the negedge just after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg);
        issue_valid = 1'b1; issue_op = op; issue_rs1 = a; issue_rs2 = b; issue_tag = tg;
        #1 check_eq("issue_ready", issue_ready, 1);
        @(negedge clk);
        issue_valid = 1'b0;
    endtask

    // lat counts edges after the accepting edge until wb_valid is seen.
    task automatic wait_result(input logic [31:0] exp_d, input logic [4:0] exp_t, input int exp_lat, input logic exp_err);
        int lat, en;
        lat = 0; en = 0;
        while (!wb_valid && lat < 40) begin
            en += int'(core_clk_en);
            check_eq("rdy_busy", issue_ready, 0);
            @(negedge clk);
            lat++;
        end
        check_eq("latency", lat, exp_lat);
        check_eq("clk_en_cycles", en, (exp_lat == 0) ? 0 : 17);
        check_eq("wb_data", wb_data, exp_d);
        check_eq("wb_tag", wb_tag, exp_t);
        check_eq("seq_err", seq_err, exp_err);
    endtask

    task automatic retire(input int hold, input logic [31:0] exp_d, input logic [4:0] exp_t);
        for (int k = 0; k < hold; k++) begin
            check_eq("hold_data", wb_data, exp_d);
            check_eq("hold_tag", wb_tag, exp_t);
            check_eq("hold_rdy", issue_ready, 0);
            @(negedge clk);
        end
        check_eq("wb_valid_before", wb_valid, 1);
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        check_eq("wb_valid_after", wb_valid, 0);
        check_eq("rdy_after", issue_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b, e;
        logic [4:0]  tg;
        int          hold, en;

        rst_n = 1'b0; issue_valid = 1'b0; issue_op = 2'b00; issue_rs1 = 32'd0; issue_rs2 = 32'd0;
        issue_tag = 5'd0; flush = 1'b0; wb_ready = 1'b0; core_stall = 1'b0;
        @(negedge clk); @(negedge clk);
        check_eq("rst_ready", issue_ready, 1);
        check_eq("rst_clk_en", core_clk_en, 0);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_seq_err", seq_err, 0);
        check_eq("rst_wb_data", wb_data, 0);
        check_eq("rst_core_a", core_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1
        issue(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd5);
        wait_result(32'hFFFF_FFEB, 5'd5, 18, 1'b0);
        retire(0, 32'hFFFF_FFEB, 5'd5);

        // T2
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1);
        wait_result(32'h4000_0000, 5'd1, 18, 1'b0);
        retire(1, 32'h4000_0000, 5'd1);
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        wait_result(32'hFFFF_FFFE, 5'd2, 18, 1'b0);
        retire(0, 32'hFFFF_FFFE, 5'd2);
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        wait_result(32'hFFFF_FFFF, 5'd3, 18, 1'b0);
        retire(0, 32'hFFFF_FFFF, 5'd3);

        // T3
        issue(2'b00, 32'h1234, 32'd0, 5'd4);
        wait_result(32'd0, 5'd4, 0, 1'b0);
        retire(0, 32'd0, 5'd4);

        // T4: flush raised during the fifth RUN cycle
        issue(2'b00, 32'd100, 32'd200, 5'd6);
        for (int k = 0; k < 4; k++) @(negedge clk);
        check_eq("flush_pre_en", core_clk_en, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        en = 0;
        while (core_clk_en && en < 40) begin
            check_eq("drain_rdy", issue_ready, 0);
            check_eq("drain_valid", wb_valid, 0);
            en++;
            @(negedge clk);
        end
        check_eq("drain_cycles", en, 12);
        check_eq("drain_idle_rdy", issue_ready, 1);
        check_eq("drain_no_valid", wb_valid, 0);
        issue(2'b00, 32'd3, 32'd4, 5'd7);
        wait_result(32'd12, 5'd7, 18, 1'b0);
        retire(0, 32'd12, 5'd7);

        // T5: back-pressure, then retire and accept on the same edge
        issue(2'b11, 32'h8000_0001, 32'd5, 5'd8);
        e = ref_mul(2'b11, 32'h8000_0001, 32'd5);
        wait_result(e, 5'd8, 18, 1'b0);
        for (int k = 0; k < 10; k++) begin
            check_eq("bp_data", wb_data, e);
            check_eq("bp_tag", wb_tag, 5'd8);
            check_eq("bp_rdy", issue_ready, 0);
            @(negedge clk);
        end
        wb_ready = 1'b1;
        issue(2'b00, 32'd5, 32'd6, 5'd9);
        wb_ready = 1'b0;
        check_eq("b2b_valid", wb_valid, 0);
        check_eq("b2b_en", core_clk_en, 1);
        wait_result(32'd30, 5'd9, 18, 1'b0);
        retire(0, 32'd30, 5'd9);

        // Randomized ops against the reference
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            a = pick(); b = pick(); tg = 5'($urandom);
            hold = $urandom_range(0, 3);
            e = ref_mul(op, a, b);
            issue(op, a, b, tg);
            wait_result(e, tg, (a == 32'd0 || b == 32'd0) ? 0 : 18, 1'b0);
            retire(hold, e, tg);
        end

        // Core reported busy at sample time: sticky error
        core_stall = 1'b1;
        issue(2'b00, 32'd2, 32'd3, 5'd10);
        wait_result(32'd6, 5'd10, 18, 1'b1);
        retire(0, 32'd6, 5'd10);
        core_stall = 1'b0;
        issue(2'b00, 32'd4, 32'd5, 5'd11);
        wait_result(32'd20, 5'd11, 18, 1'b1);
        retire(0, 32'd20, 5'd11);

        // T6: async reset mid-RUN
        issue(2'b00, 32'd9, 32'd9, 5'd12);
        for (int k = 0; k < 5; k++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_clk_en", core_clk_en, 0);
        check_eq("arst_ready", issue_ready, 1);
        check_eq("arst_valid", wb_valid, 0);
        check_eq("arst_err", seq_err, 0);
        check_eq("arst_data", wb_data, 0);
        check_eq("arst_core_a", core_a, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'b11, 32'd2, 32'd3, 5'd13);
        wait_result(32'd0, 5'd13, 18, 1'b0);
        retire(0, 32'd0, 5'd13);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
